// File: rtl/spi_target_if.sv
// Byte-level handshake and SPI pin bundle between the SPI target and its host-side logic.
interface spi_target_if;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  spi_sck, spi_mosi, spi_ss_n, rx_ack, tx_data, tx_load,
        output spi_miso, spi_miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy
    );

    modport master (
        output spi_sck, spi_mosi, spi_ss_n, rx_ack, tx_data, tx_load,
        input  spi_miso, spi_miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCK/MOSI/SS_n in the clk domain, MSB-first 8-bit frames,
// single-entry TX buffer and single RX holding register with overrun/underrun pulses.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input logic         clk,
    input logic         rst_n,
    spi_target_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_n_sync_q;
    logic                   sck_dly_q, ss_n_dly_q;
    logic                   sck_s, mosi_s, ss_n_s;
    logic                   sck_rise, sck_fall, ss_fall, ss_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_n_s   = ss_n_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign ss_fall  = ~ss_n_s & ss_n_dly_q;
    assign ss_rise  = ss_n_s & ~ss_n_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_n_sync_q <= '1;
            sck_dly_q   <= 1'b0;
            ss_n_dly_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n};
            sck_dly_q   <= sck_s;
            ss_n_dly_q  <= ss_n_s;
        end
    end

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       tx_full_q, tx_full_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       miso_oe_q, miso_oe_d;
    logic       reload;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~bus.rx_ack;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        miso_oe_d     = miso_oe_q;
        reload        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d   = StActive;
                    bit_cnt_d = 3'd0;
                    miso_oe_d = 1'b1;
                    reload    = 1'b1;
                end
            end
            StActive: begin
                // Deselect takes priority over any SCK edge seen in the same cycle.
                if (ss_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = 3'd0;
                    miso_oe_d = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d    = {rx_shift_q, mosi_s};
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid_q & ~bus.rx_ack;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        reload = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            tx_shift_d    = tx_full_q ? tx_buf_q : IDLE_BYTE;
            tx_full_d     = 1'b0;
            tx_underrun_d = ~tx_full_q;
        end

        // A load coinciding with a reload is accepted: the shifter has just taken the old byte.
        if (bus.tx_load && (!tx_full_q || reload)) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    // MISO idles high whenever the output is not enabled.
    assign bus.spi_miso    = miso_oe_q ? tx_shift_q[7] : 1'b1;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_ready    = ~tx_full_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = (state_q == StActive);
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI host plus a queue-based model of the TX buffer and RX register.
module tb_spi_target;
    localparam int unsigned S    = 2;
    localparam logic [7:0]  IDLE = 8'hFF;
    localparam int          H    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_target_if bus ();

    spi_target #(.SYNC_STAGES(S), .IDLE_BYTE(IDLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int und_cnt = 0;
    int ovr_cnt = 0;

    // Reference model state
    logic [7:0] txq[$];
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         exp_und = 0;
    int         exp_ovr = 0;
    logic [7:0] exp_cur;
    logic [7:0] hb [0:3];

    always @(posedge clk) begin
        #1;
        if (bus.tx_underrun === 1'b1) und_cnt++;
        if (bus.rx_overrun === 1'b1) ovr_cnt++;
    end

    initial begin
        #400_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic next_tx(output logic [7:0] v);
        if (txq.size() > 0) v = txq.pop_front();
        else begin
            v = IDLE;
            exp_und++;
        end
    endtask

    task automatic model_load(input logic [7:0] v);
        if (txq.size() == 0) txq.push_back(v);
    endtask

    task automatic model_rx(input logic [7:0] v, input bit ack);
        if (m_valid && !ack) exp_ovr++;
        m_valid = 1'b1;
        m_data  = v;
    endtask

    task automatic load_tx(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        tick(1);
        model_load(v);
    endtask

    task automatic ack_rx();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        tick(1);
        m_valid = 1'b0;
    endtask

    // hook bit0: tx_load lands on the byte-boundary reload; bit1: rx_ack lands on byte completion;
    // bit2: check rx_valid appears exactly S+1 clk after the 8th rise.
    task automatic xfer(input logic [7:0] mo, input int nbits, input int hook,
                        input logic [7:0] ld, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mo[7-i];
            if (i == 0 && (hook & 1) != 0) begin
                tick(S);
                bus.tx_data = ld;
                bus.tx_load = 1'b1;
                tick(1);
                bus.tx_load = 1'b0;
                tick(H - S - 1);
            end else tick(H);
            mi[7-i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            if (i == 7 && (hook & 2) != 0) begin
                tick(S);
                bus.rx_ack = 1'b1;
                tick(1);
                bus.rx_ack = 1'b0;
                tick(H - S - 1);
            end else if (i == 7 && (hook & 4) != 0) begin
                tick(S);
                check("rx_valid_before_latency", bus.rx_valid, 0);
                tick(1);
                check("rx_valid_at_latency", bus.rx_valid, 1);
                tick(H - S - 1);
            end else tick(H);
        end
    endtask

    task automatic frame_start();
        bus.spi_ss_n = 1'b0;
        tick(H);
        next_tx(exp_cur);
        check("busy_in_frame", bus.busy, 1);
        check("miso_oe_in_frame", bus.spi_miso_oe, 1);
    endtask

    // SS_n rises with SCK still high; the trailing SCK fall then lands in idle and is ignored.
    task automatic frame_end();
        bus.spi_ss_n = 1'b1;
        tick(H);
        bus.spi_sck = 1'b0;
        tick(H);
    endtask

    task automatic host_byte(input logic [7:0] mo, input bit first, input int hook,
                             input logic [7:0] ld);
        logic [7:0] mi;
        if (!first) next_tx(exp_cur);
        if ((hook & 1) != 0) model_load(ld);
        xfer(mo, 8, hook, ld, mi);
        check("miso_byte", mi, exp_cur);
        model_rx(mo, (hook & 2) != 0);
    endtask

    task automatic end_checks();
        check("rx_data", bus.rx_data, m_data);
        check("rx_valid", bus.rx_valid, m_valid);
        check("tx_ready", bus.tx_ready, txq.size() == 0);
        check("underrun_count", und_cnt, exp_und);
        check("overrun_count", ovr_cnt, exp_ovr);
        check("busy_idle", bus.busy, 0);
        check("miso_oe_idle", bus.spi_miso_oe, 0);
        check("miso_idle", bus.spi_miso, 1);
    endtask

    task automatic reset_checks();
        check("rst_miso", bus.spi_miso, 1);
        check("rst_miso_oe", bus.spi_miso_oe, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_overrun", bus.rx_overrun, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_tx_underrun", bus.tx_underrun, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    task automatic do_frame(input int n);
        frame_start();
        for (int b = 0; b < n; b++) host_byte(hb[b], b == 0, 0, 8'h00);
        frame_end();
        end_checks();
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] r;
        int         n;

        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss_n = 1'b1;
        bus.rx_ack   = 1'b0;
        bus.tx_load  = 1'b0;
        bus.tx_data  = 8'h00;
        tick(3);
        reset_checks();
        rst_n = 1'b1;
        tick(4);

        // Preloaded A5 out, 3C in, with RX latency check
        load_tx(8'hA5);
        check("tx_ready_after_load", bus.tx_ready, 0);
        frame_start();
        check("tx_ready_after_start", bus.tx_ready, 1);
        host_byte(8'h3C, 1'b1, 4, 8'h00);
        frame_end();
        end_checks();

        // Three-byte frame, only the first byte buffered
        ack_rx();
        load_tx(8'h01);
        hb[0] = 8'($urandom); hb[1] = 8'($urandom); hb[2] = 8'($urandom);
        do_frame(3);

        // Two bytes without acknowledge
        ack_rx();
        hb[0] = 8'h11; hb[1] = 8'h22;
        do_frame(2);

        // Aborted byte then a clean one
        ack_rx();
        frame_start();
        xfer(8'hF0, 5, 0, 8'h00, mi);
        check("partial_miso", {27'd0, mi[7:3]}, {27'd0, exp_cur[7:3]});
        frame_end();
        end_checks();
        hb[0] = 8'h0F;
        do_frame(1);

        // Reset mid-byte with the TX buffer full; SS_n stays low through reset
        ack_rx();
        frame_start();
        load_tx(8'($urandom));
        check("tx_ready_full", bus.tx_ready, 0);
        xfer(8'($urandom), 4, 0, 8'h00, mi);
        bus.spi_sck = 1'b0;
        tick(H);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        txq.delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        reset_checks();
        tick(2);
        check("busy_before_restart", bus.busy, 0);
        tick(1);
        check("busy_restart_latency", bus.busy, 1);
        next_tx(exp_cur);
        tick(H - 3);
        host_byte(8'($urandom), 1'b1, 0, 8'h00);
        frame_end();
        end_checks();

        // Coincident ack with completion; coincident load with a full-buffer reload
        ack_rx();
        load_tx(8'($urandom));
        frame_start();
        load_tx(8'($urandom));
        host_byte(8'($urandom), 1'b1, 0, 8'h00);
        r = 8'($urandom);
        host_byte(8'($urandom), 1'b0, 3, r);
        frame_end();
        end_checks();

        // Coincident load with an empty-buffer reload: idle byte goes out, new byte kept
        frame_start();
        host_byte(8'($urandom), 1'b1, 0, 8'h00);
        r = 8'($urandom);
        host_byte(8'($urandom), 1'b0, 1, r);
        frame_end();
        end_checks();

        // Random frames
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) ack_rx();
            if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
            n = int'($urandom_range(1, 3));
            for (int b = 0; b < n; b++) hb[b] = 8'($urandom);
            do_frame(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
